// File: rtl/line_fill_unit.sv
// Line fill unit: queues cache line-read misses, issues one burst read per line
// to memory and streams the returned words back to the cache as indexed fill beats.
module line_fill_unit #(
  parameter int LINEITEMS = 16,
  parameter int WORDW     = 32,
  parameter int LADDRW    = 26,
  parameter int QDEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  input  logic [LADDRW-1:0]            req_laddr,
  output logic                         req_ready,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [31:0]                  mem_addr,
  input  logic                         mem_rvalid,
  input  logic [WORDW-1:0]             mem_rdata,
  output logic                         fill_valid,
  output logic [LADDRW-1:0]            fill_laddr,
  output logic [$clog2(LINEITEMS)-1:0] fill_idx,
  output logic [WORDW-1:0]             fill_data,
  output logic                         fill_last,
  output logic                         busy,
  output logic [31:0]                  fills,
  output logic [31:0]                  merged
);

  localparam int IDXW = $clog2(LINEITEMS);
  localparam int QAW  = $clog2(QDEPTH);
  localparam int CNTW = QAW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BEAT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [LADDRW-1:0] q_mem [QDEPTH];
  logic [QAW-1:0]    wr_ptr, rd_ptr;
  logic [CNTW-1:0]   count, count_nxt;
  logic [1:0]        state;
  logic [LADDRW-1:0] infl;
  logic [IDXW-1:0]   beat_cnt;
  logic              dup, accept, push, pop;

  // Only entries between rd_ptr and rd_ptr+count-1 are live; the head being
  // popped this cycle still counts, so a same-cycle duplicate is caught.
  always_comb begin
    dup = (state != S_IDLE) && (infl == req_laddr);
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      if ((CNTW'(i) < count) && (q_mem[rd_ptr + QAW'(i)] == req_laddr))
        dup = 1'b1;
    end
  end

  assign accept    = req_valid && req_ready;
  assign push      = accept && !dup;
  assign pop       = (state == S_IDLE) && (count != '0);
  assign count_nxt = count + CNTW'(push) - CNTW'(pop);

  assign mem_req_valid = (state == S_ISSUE);
  assign mem_addr      = {infl, {(32-LADDRW){1'b0}}};
  assign busy          = (count != '0) || (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= req_laddr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      req_ready  <= 1'b1;
      state      <= S_IDLE;
      infl       <= '0;
      beat_cnt   <= '0;
      fill_valid <= 1'b0;
      fill_laddr <= '0;
      fill_idx   <= '0;
      fill_data  <= '0;
      fill_last  <= 1'b0;
      fills      <= '0;
      merged     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_nxt;
      req_ready <= (count_nxt < CNTW'(QDEPTH));
      if (accept && dup) merged <= merged + 1'b1;

      fill_valid <= 1'b0;
      fill_last  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pop) begin
            infl  <= q_mem[rd_ptr];
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          beat_cnt <= '0;
          if (mem_req_ready) state <= S_BEAT;
        end
        S_BEAT: begin
          if (mem_rvalid) begin
            fill_valid <= 1'b1;
            fill_idx   <= beat_cnt;
            fill_data  <= mem_rdata;
            fill_laddr <= infl;
            fill_last  <= (beat_cnt == IDXW'(LINEITEMS-1));
            beat_cnt   <= beat_cnt + 1'b1;
            if (beat_cnt == IDXW'(LINEITEMS-1)) state <= S_DONE;
          end
        end
        default: begin
          fills <= fills + 1'b1;
          infl  <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_fill_unit.sv
// Bench for line_fill_unit: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based transaction model.
module tb_line_fill_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [25:0] req_laddr;
  logic        req_ready;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        fill_valid;
  logic [25:0] fill_laddr;
  logic [3:0]  fill_idx;
  logic [31:0] fill_data;
  logic        fill_last;
  logic        busy;
  logic [31:0] fills;
  logic [31:0] merged;

  line_fill_unit #(.LINEITEMS(16), .WORDW(32), .LADDRW(26), .QDEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_laddr(req_laddr), .req_ready(req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fill_valid(fill_valid), .fill_laddr(fill_laddr), .fill_idx(fill_idx),
    .fill_data(fill_data), .fill_last(fill_last),
    .busy(busy), .fills(fills), .merged(merged)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fill_cnt = 0;
  bit chk_en = 1'b0;
  bit rand_mem = 1'b0;

  // Transaction model: pending line queue plus the one line owned by memory.
  logic [25:0] mq[$];
  bit          m_infl_v, m_issued;
  logic [25:0] m_infl;
  int          m_beats, m_issues;
  logic [31:0] m_fills, m_merged;
  bit          e_fv, e_last;
  logic [3:0]  e_idx;
  logic [31:0] e_data;
  logic [25:0] e_laddr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_infl_v = 0; m_issued = 0; m_infl = '0; m_beats = 0; m_issues = 0;
      m_fills = '0; m_merged = '0;
      e_fv = 0; e_last = 0; e_idx = '0; e_data = '0; e_laddr = '0;
    end else begin
      bit dup, do_push;
      e_fv   = m_infl_v && m_issued && (m_beats < 16) && mem_rvalid;
      e_last = e_fv && (m_beats == 15);
      if (e_fv) begin
        e_idx = 4'(m_beats); e_data = mem_rdata; e_laddr = m_infl;
      end
      dup = m_infl_v && (m_infl == req_laddr);
      foreach (mq[i]) if (mq[i] == req_laddr) dup = 1;
      do_push = 0;
      if (req_valid && (mq.size() < 4)) begin
        if (dup) m_merged++;
        else     do_push = 1;
      end
      if (!m_infl_v) begin
        if (mq.size() != 0) begin
          m_infl = mq.pop_front(); m_infl_v = 1; m_issued = 0; m_beats = 0;
        end
      end else if (!m_issued) begin
        if (mem_req_ready) begin m_issued = 1; m_issues++; end
      end else if (m_beats < 16) begin
        if (mem_rvalid) m_beats++;
      end else begin
        m_fills++; m_infl_v = 0; m_infl = '0;
      end
      if (do_push) mq.push_back(req_laddr);
    end
  end

  always @(negedge clk) begin
    if (fill_valid === 1'b1) fill_cnt++;
    if (chk_en) begin
      chk("req_ready", req_ready, mq.size() < 4);
      chk("mem_req_valid", mem_req_valid, m_infl_v && !m_issued);
      chk("mem_addr", mem_addr, m_infl_v ? {m_infl, 6'b0} : 32'h0);
      chk("busy", busy, (mq.size() != 0) || m_infl_v);
      chk("fills", fills, m_fills);
      chk("merged", merged, m_merged);
      chk("fill_valid", fill_valid, e_fv);
      chk("fill_last", fill_last, e_last);
      if (e_fv) begin
        chk("fill_idx", fill_idx, e_idx);
        chk("fill_data", fill_data, e_data);
        chk("fill_laddr", fill_laddr, e_laddr);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    if (rand_mem) begin
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_rvalid    = ($urandom_range(0, 3) != 0);
      mem_rdata     = $urandom;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0; mem_rvalid = 1'b0; mem_req_ready = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [25:0] a);
    int k;
    for (k = 0; k < 3000 && !req_ready; k++) cyc();
    if (!req_ready) begin
      chk("send_timeout", 0, 1);
    end else begin
      req_valid = 1'b1; req_laddr = a;
      cyc();
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_issue();
    int k;
    for (k = 0; k < 100 && !mem_req_valid; k++) cyc();
    if (!mem_req_valid) chk("issue_timeout", 0, 1);
  endtask

  task automatic drive_beats(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      mem_rvalid = 1'b1; mem_rdata = base + 32'(i);
      cyc();
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 5000 && busy; k++) cyc();
    if (busy) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int fc;
    rst_n = 1'b0; req_valid = 1'b0; req_laddr = '0;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst_n = 1'b1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fills", fills, 0);
    chk("rst_merged", merged, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);

    // single miss
    fc = fill_cnt;
    mem_req_ready = 1'b1;
    send(26'h0000ABC);
    wait_issue();
    chk("single_mem_addr", mem_addr, 32'h0002AF00);
    cyc();
    drive_beats(16, 32'h1000);
    cyc(); cyc();
    chk("single_fills", fills, 1);
    chk("single_beats", fill_cnt - fc, 16);
    chk("single_idle", busy, 0);

    // full FIFO with memory stalled
    do_reset();
    for (int i = 0; i < 5; i++) send(26'h200 + 26'(i));
    chk("full_ready_low", req_ready, 0);
    chk("full_model_depth", mq.size(), 4);
    for (int i = 0; i < 10; i++) cyc();
    chk("full_still_held", req_ready, 0);
    rand_mem = 1'b1;
    send(26'h205);
    wait_idle();
    rand_mem = 1'b0; mem_rvalid = 1'b0;
    cyc();
    chk("full_fills", fills, 6);

    // duplicate suppression, including against the in-flight line
    do_reset();
    send(26'h100);
    send(26'h100);
    mem_req_ready = 1'b1;
    wait_issue();
    cyc();
    mem_req_ready = 1'b0;
    drive_beats(3, 32'h5000);
    send(26'h100);
    drive_beats(13, 32'h6000);
    cyc(); cyc();
    chk("dup_merged", merged, 2);
    chk("dup_model_issues", m_issues, 1);
    chk("dup_fills", fills, 1);

    // reset in the middle of a burst
    do_reset();
    mem_req_ready = 1'b1;
    send(26'h055);
    wait_issue();
    cyc();
    drive_beats(7, 32'h7000);
    mem_rvalid = 1'b1; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    fc = fill_cnt;
    drive_beats(9, 32'h8000);
    cyc();
    chk("midrst_no_fill", fill_cnt - fc, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_fills", fills, 0);

    // stray beat while idle
    fc = fill_cnt;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    cyc(); cyc(); cyc();
    mem_rvalid = 1'b0;
    cyc();
    chk("stray_no_fill", fill_cnt - fc, 0);
    chk("stray_fills", fills, 0);
    chk("stray_merged", merged, 0);

    // random traffic over a small address pool to provoke duplicates
    rand_mem = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_laddr = 26'h3F0 + 26'($urandom_range(0, 7));
      rst_n     = ($urandom_range(0, 799) != 0);
      cyc();
    end
    rst_n = 1'b1; req_valid = 1'b0;
    wait_idle();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
